// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: select codes, FSM states, grant
// vector type and the reserved-select test.
package alu_pkg;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    // Wide enough for the largest legal LATENCY (15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // One-hot grant; bit i belongs to requester i.
    typedef logic [1:0] grant_t;

    // Selects 100..111 have no ALU function behind them.
    function automatic logic is_reserved(input logic [2:0] sel);
        return sel[2];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker. The pointer names the requester that wins
// a tie; a lone valid always wins.
module rr_arb2
    import alu_pkg::*;
(
    input  logic   valid0,
    input  logic   valid1,
    input  logic   ptr,
    output grant_t grant
);

    // NOTE: assigning every always_comb output a default first means no path
    // leaves it unassigned, so no latch is inferred.
    always_comb begin
        grant = 2'b00;
        if (valid0 && (!valid1 || !ptr)) begin
            grant[0] = 1'b1;
        end else if (valid1) begin
            grant[1] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters: round-robin grant, fixed
// settle latency on registered ALU inputs, single tagged response strobe.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DATA_W  = 8,
    parameter int SEL_W   = 3
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [SEL_W-1:0]  req0_select,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [SEL_W-1:0]  req1_select,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,

    output logic [SEL_W-1:0]  alu_select,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    input  logic [DATA_W-1:0] alu_result,

    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic              ptr;
    logic [CNT_W-1:0]  cnt;
    logic              cur_id;

    grant_t            grant;
    logic              accept;
    logic              capture;
    logic              win_id;
    logic              win_rsv;
    logic [SEL_W-1:0]  win_sel;
    logic [DATA_W-1:0] win_op1;
    logic [DATA_W-1:0] win_op2;

    rr_arb2 u_rr_arb2 (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .ptr    (ptr),
        .grant  (grant)
    );

    assign win_id  = grant[1];
    assign win_sel = win_id ? req1_select : req0_select;
    assign win_op1 = win_id ? req1_op1    : req0_op1;
    assign win_op2 = win_id ? req1_op2    : req0_op2;
    assign win_rsv = is_reserved(win_sel[2:0]);

    // READY is qualified with resetn so no requester sees an accept while
    // reset is held, even though the state is already IDLE.
    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                req0_ready = grant[0] & resetn;
                req1_ready = grant[1] & resetn;
                accept     = req0_ready | req1_ready;
                if (accept) begin
                    state_nxt = win_rsv ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every register here is a plain flop (no memory array), so all of
    // them take the asynchronous reset and come up in a defined state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr        <= 1'b0;
            cnt        <= '0;
            cur_id     <= 1'b0;
            alu_select <= '0;
            alu_data1  <= '0;
            alu_data2  <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                ptr    <= ~win_id;
                cur_id <= win_id;
                if (win_rsv) begin
                    // Error path: respond immediately, ALU inputs untouched.
                    rsp_id     <= win_id;
                    rsp_result <= '0;
                    rsp_err    <= 1'b1;
                end else begin
                    alu_select <= win_sel;
                    alu_data1  <= win_op1;
                    alu_data2  <= win_op2;
                    cnt        <= CNT_W'(LATENCY - 1);
                end
            end else if (capture) begin
                rsp_id     <= cur_id;
                rsp_result <= alu_result;
                rsp_err    <= 1'b0;
            end else if (state == EXEC) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

endmodule
